// File: rtl/sbox_ti_pkg.sv
// Shared types, constants and GF(2^8) helpers for the 3-share AES S-box array.
// Every helper works share-wise or on share pairs only, so none of them recombines all three shares.
package sbox_ti_pkg;

  localparam int   SHARE_W      = 8;
  localparam int   RND_PER_LANE = 16;
  localparam logic MODE_FWD     = 1'b0;
  localparam logic MODE_INV     = 1'b1;

  typedef logic [SHARE_W-1:0] share_t;
  typedef struct packed {
    share_t s1;
    share_t s2;
    share_t s3;
  } shares_t;

  // Multiplication in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic share_t gf_mul(share_t a, share_t b);
    share_t p;
    share_t aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < SHARE_W; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic share_t aff_lin(share_t b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]};
  endfunction

  function automatic share_t inv_aff_lin(share_t b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]};
  endfunction

  // Non-complete product: output share i never sees input share i.
  function automatic shares_t ti_mul(shares_t a, shares_t b);
    shares_t z;
    z.s1 = gf_mul(a.s2, b.s2) ^ gf_mul(a.s2, b.s3) ^ gf_mul(a.s3, b.s2);
    z.s2 = gf_mul(a.s3, b.s3) ^ gf_mul(a.s1, b.s3) ^ gf_mul(a.s3, b.s1);
    z.s3 = gf_mul(a.s1, b.s1) ^ gf_mul(a.s1, b.s2) ^ gf_mul(a.s2, b.s1);
    return z;
  endfunction

  function automatic shares_t ti_sq(shares_t a);
    shares_t z;
    z.s1 = gf_mul(a.s1, a.s1);
    z.s2 = gf_mul(a.s2, a.s2);
    z.s3 = gf_mul(a.s3, a.s3);
    return z;
  endfunction

  function automatic shares_t refresh(shares_t a, share_t ra, share_t rb);
    shares_t z;
    z.s1 = a.s1 ^ ra;
    z.s2 = a.s2 ^ rb;
    z.s3 = a.s3 ^ ra ^ rb;
    return z;
  endfunction

endpackage

// File: rtl/sbox_ti_if.sv
// Input/output stream bundle for the shared S-box array.
interface sbox_ti_if import sbox_ti_pkg::*; #(parameter int LANES = 4);
  logic                            in_valid;
  logic                            in_ready;
  logic                            in_mode;
  logic [SHARE_W*LANES-1:0]        in1, in2, in3;
  logic [RND_PER_LANE*LANES-1:0]   rnd;
  logic                            out_valid;
  logic                            out_ready;
  logic [SHARE_W*LANES-1:0]        out1, out2, out3;
  logic [15:0]                     tx_count;

  modport master (output in_valid, in_mode, in1, in2, in3, rnd, out_ready,
                  input  in_ready, out_valid, out1, out2, out3, tx_count);
  modport slave  (input  in_valid, in_mode, in1, in2, in3, rnd, out_ready,
                  output in_ready, out_valid, out1, out2, out3, tx_count);
endinterface

// File: rtl/sbox_ti_array_lane.sv
// One S-box lane: mode-selected input affine, shared inversion x^254, CORE_LAT-deep share pipeline,
// then the forward affine on the way out. The output map uses the mode that travelled with the data.
module sbox_ti_lane import sbox_ti_pkg::*; #(
  parameter int CORE_LAT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode_in,
  input  logic                    mode_out,
  input  shares_t                 din,
  input  logic [RND_PER_LANE-1:0] rnd,
  output shares_t                 dout
);

  shares_t mapped, x2, x3, x12, x14, x15, x240, inv_o;
  shares_t pipe [CORE_LAT];

  always_comb begin
    mapped = din;
    if (mode_in == MODE_INV) begin
      mapped.s1 = inv_aff_lin(din.s1) ^ 8'h05;
      mapped.s2 = inv_aff_lin(din.s2);
      mapped.s3 = inv_aff_lin(din.s3);
    end
  end

  // x^254 = x^240 * x^14; squarings are linear and stay per-share.
  assign x2    = ti_sq(mapped);
  assign x3    = refresh(ti_mul(x2, mapped), rnd[7:0], rnd[15:8]);
  assign x12   = ti_sq(ti_sq(x3));
  assign x14   = ti_mul(x12, x2);
  assign x15   = ti_mul(x12, x3);
  assign x240  = ti_sq(ti_sq(ti_sq(ti_sq(x15))));
  assign inv_o = refresh(ti_mul(x240, x14), rnd[15:8], rnd[7:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CORE_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= inv_o;
      for (int i = 1; i < CORE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_comb begin
    dout = pipe[CORE_LAT-1];
    if (mode_out == MODE_FWD) begin
      dout.s1 = aff_lin(pipe[CORE_LAT-1].s1) ^ 8'h63;
      dout.s2 = aff_lin(pipe[CORE_LAT-1].s2);
      dout.s3 = aff_lin(pipe[CORE_LAT-1].s3);
    end
  end

endmodule

// File: rtl/sbox_ti_array.sv
// LANES shared S-box lanes behind a credit-controlled output FIFO; the core never stalls,
// so credits (in-flight + buffered) gate in_ready and guarantee a FIFO slot for every result.
module sbox_ti_array import sbox_ti_pkg::*; #(
  parameter int LANES    = 4,
  parameter int CORE_LAT = 3,
  parameter int DEPTH    = 8
) (
  input  logic      clk,
  input  logic      rst,
  sbox_ti_if.slave  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam int DW = SHARE_W * LANES;

  logic                          fire, pop, push;
  logic [CORE_LAT-1:0]           vld_sr, mode_sr;
  logic [CW-1:0]                 credits, fifo_cnt;
  logic [PW-1:0]                 wr_ptr, rd_ptr;
  logic [RND_PER_LANE*LANES-1:0] rnd_gated;
  logic [DW-1:0]                 wr1, wr2, wr3;
  logic [DW-1:0]                 mem1 [DEPTH];
  logic [DW-1:0]                 mem2 [DEPTH];
  logic [DW-1:0]                 mem3 [DEPTH];

  assign fire      = bus.in_valid && bus.in_ready;
  assign pop       = bus.out_valid && bus.out_ready;
  assign push      = vld_sr[CORE_LAT-1];
  assign rnd_gated = fire ? bus.rnd : '0;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    shares_t lin, lout;
    assign lin = {bus.in1[SHARE_W*k +: SHARE_W], bus.in2[SHARE_W*k +: SHARE_W],
                  bus.in3[SHARE_W*k +: SHARE_W]};
    sbox_ti_lane #(.CORE_LAT(CORE_LAT)) u_lane (
      .clk      (clk),
      .rst_n    (rst),
      .mode_in  (bus.in_mode),
      .mode_out (mode_sr[CORE_LAT-1]),
      .din      (lin),
      .rnd      (rnd_gated[RND_PER_LANE*k +: RND_PER_LANE]),
      .dout     (lout)
    );
    assign wr1[SHARE_W*k +: SHARE_W] = lout.s1;
    assign wr2[SHARE_W*k +: SHARE_W] = lout.s2;
    assign wr3[SHARE_W*k +: SHARE_W] = lout.s3;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem1[i] <= '0;
        mem2[i] <= '0;
        mem3[i] <= '0;
      end
    end else if (push) begin
      mem1[wr_ptr] <= wr1;
      mem2[wr_ptr] <= wr2;
      mem3[wr_ptr] <= wr3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_sr   <= '0;
      mode_sr  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      credits  <= '0;
      bus.tx_count <= '0;
    end else begin
      vld_sr[0]  <= fire;
      mode_sr[0] <= bus.in_mode;
      for (int i = 1; i < CORE_LAT; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        mode_sr[i] <= mode_sr[i-1];
      end
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr       <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
        bus.tx_count <= bus.tx_count + 16'd1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({fire, pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  assign bus.in_ready  = (credits < CW'(DEPTH));
  assign bus.out_valid = (fifo_cnt != '0);
  assign bus.out1      = mem1[rd_ptr];
  assign bus.out2      = mem2[rd_ptr];
  assign bus.out3      = mem3[rd_ptr];

endmodule

// File: tb/tb_sbox_ti_array.sv
// Directed bench for sbox_ti_array: vector table for S-box values and latency, plus sequences for
// streaming, back-pressure, credit boundary and mid-flight reset. Reference is the published AES table.
module tb_sbox_ti_array;
  import sbox_ti_pkg::*;

  localparam int LANES = 4, CORE_LAT = 3, DEPTH = 8;
  localparam int DW = 8 * LANES;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sbox_ti_if #(.LANES(LANES)) bus ();
  sbox_ti_array #(.LANES(LANES), .CORE_LAT(CORE_LAT), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [127:0] sbox_rows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  logic [7:0] inv_tbl [256];

  typedef struct {
    logic       mode;
    logic [7:0] s1, s2, s3;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [8];

  int n_cmp = 0, n_bad = 0, n_out = 0;
  int cyc = 0, first_cyc = 0, last_cyc = 0;
  bit mon_en = 1'b0;
  logic [DW-1:0] exp_q [$];

  always @(posedge clk) cyc++;

  function automatic logic [7:0] sbox_f(logic [7:0] x);
    logic [127:0] row;
    row = sbox_rows[x[7:4]];
    return row[8*(15 - int'(x[3:0])) +: 8];
  endfunction

  function automatic logic [DW-1:0] expect_vec(logic m, logic [DW-1:0] xv);
    logic [DW-1:0] r;
    for (int k = 0; k < LANES; k++)
      r[8*k +: 8] = m ? inv_tbl[xv[8*k +: 8]] : sbox_f(xv[8*k +: 8]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic m, input logic [DW-1:0] xv);
    logic [7:0] a, b;
    bus.in_mode = m;
    bus.rnd     = {$urandom(), $urandom()};
    for (int k = 0; k < LANES; k++) begin
      a = 8'($urandom());
      b = 8'($urandom());
      bus.in1[8*k +: 8] = a;
      bus.in2[8*k +: 8] = b;
      bus.in3[8*k +: 8] = xv[8*k +: 8] ^ a ^ b;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    exp_q.delete();
    n_out = 0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input string name, input int target);
    for (int t = 0; t < 200 && n_out < target; t++) tick();
    chk(name, 64'(n_out), 64'(target));
  endtask

  always @(negedge clk) begin
    if (mon_en && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got %0h expected none", bus.out1 ^ bus.out2 ^ bus.out3);
      end else begin
        if (n_out == 0) first_cyc = cyc;
        last_cyc = cyc;
        chk("scoreboard", 64'(bus.out1 ^ bus.out2 ^ bus.out3), 64'(exp_q.pop_front()));
        n_out++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] xv, g;
    logic [7:0] m8, s1, s2, s3;
    logic md;
    int acc, stalls, sent, seen;

    for (int i = 0; i < 256; i++) inv_tbl[sbox_f(8'(i))] = 8'(i);
    vecs[0] = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h63};
    vecs[1] = '{1'b0, 8'h12, 8'h34, 8'h35, 8'h7D};
    vecs[2] = '{1'b1, 8'hA0, 8'h0F, 8'h42, 8'h53};
    vecs[3] = '{1'b1, 8'h11, 8'h22, 8'h50, 8'h00};
    vecs[4] = '{1'b0, 8'h53, 8'h00, 8'h00, 8'hED};
    vecs[5] = '{1'b0, 8'h0F, 8'hF0, 8'h00, 8'h16};
    vecs[6] = '{1'b1, 8'h16, 8'h00, 8'h00, 8'hFF};
    vecs[7] = '{1'b0, 8'h80, 8'h81, 8'h00, 8'h7C};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_mode = 1'b0;
    bus.in1 = '0; bus.in2 = '0; bus.in3 = '0; bus.rnd = '0;
    #12;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_tx_count", 64'(bus.tx_count), 64'(0));
    chk("rst_out_shares", 64'(bus.out1 | bus.out2 | bus.out3), 64'(0));
    rst = 1'b1;
    tick();

    // Table: single transactions, exact latency and per-lane value.
    for (int v = 0; v < 8; v++) begin
      bus.in_mode = vecs[v].mode;
      bus.rnd     = {$urandom(), $urandom()};
      for (int k = 0; k < LANES; k++) begin
        m8 = 8'(k * 59);
        bus.in1[8*k +: 8] = vecs[v].s1 ^ m8;
        bus.in2[8*k +: 8] = vecs[v].s2 ^ m8;
        bus.in3[8*k +: 8] = vecs[v].s3;
      end
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (CORE_LAT - 1) tick();
      chk($sformatf("vec%0d_early", v), 64'(bus.out_valid), 64'(0));
      tick();
      chk($sformatf("vec%0d_latency", v), 64'(bus.out_valid), 64'(1));
      g = bus.out1 ^ bus.out2 ^ bus.out3;
      for (int k = 0; k < LANES; k++)
        chk($sformatf("vec%0d_lane%0d", v, k), 64'(g[8*k +: 8]), 64'(vecs[v].exp));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk($sformatf("vec%0d_tx_count", v), 64'(bus.tx_count), 64'(v + 1));
    end

    // Back-to-back stream of 256 with out_ready high.
    reset_dut();
    mon_en = 1'b1;
    bus.out_ready = 1'b1;
    sent = 0; stalls = 0;
    for (int t = 0; t < 400 && sent < 256; t++) begin
      for (int k = 0; k < LANES; k++) xv[8*k +: 8] = 8'(sent + 64 * k);
      md = 1'($urandom_range(0, 1));
      load(md, xv);
      bus.in_valid = 1'b1;
      if (bus.in_ready) begin
        exp_q.push_back(expect_vec(md, xv));
        sent++;
      end else stalls++;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("stream_stalls", 64'(stalls), 64'(0));
    wait_drain("stream_count", 256);
    chk("stream_one_per_cycle", 64'(last_cyc - first_cyc), 64'(255));
    chk("stream_tx_count", 64'(bus.tx_count), 64'(256));

    // Back-pressure: exactly DEPTH accepted, then ordered drain.
    reset_dut();
    acc = 0;
    for (int t = 0; t < DEPTH + 12; t++) begin
      xv = {$urandom()};
      md = 1'($urandom_range(0, 1));
      load(md, xv);
      bus.in_valid = 1'b1;
      if (bus.in_ready) begin
        exp_q.push_back(expect_vec(md, xv));
        acc++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    chk("full_accepted", 64'(acc), 64'(DEPTH));
    chk("full_in_ready", 64'(bus.in_ready), 64'(0));
    chk("full_head", 64'(bus.out1 ^ bus.out2 ^ bus.out3), 64'(exp_q[0]));
    repeat (2) tick();
    chk("full_head_held", 64'(bus.out1 ^ bus.out2 ^ bus.out3), 64'(exp_q[0]));
    bus.out_ready = 1'b1;
    wait_drain("full_drain", DEPTH);
    chk("full_tx_count", 64'(bus.tx_count), 64'(DEPTH));
    chk("full_in_ready_after", 64'(bus.in_ready), 64'(1));

    // Credit boundary: fire and transfer together at C = DEPTH-1.
    reset_dut();
    for (int t = 0; t < DEPTH - 1; t++) begin
      xv = {$urandom()};
      load(1'b0, xv);
      bus.in_valid = 1'b1;
      exp_q.push_back(expect_vec(1'b0, xv));
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (CORE_LAT + 2) tick();
    chk("c7_in_ready", 64'(bus.in_ready), 64'(1));
    xv = {$urandom()};
    load(1'b1, xv);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.push_back(expect_vec(1'b1, xv));
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("c7_both_in_ready", 64'(bus.in_ready), 64'(1));
    xv = {$urandom()};
    load(1'b0, xv);
    bus.in_valid = 1'b1;
    exp_q.push_back(expect_vec(1'b0, xv));
    tick();
    bus.in_valid = 1'b0;
    chk("c8_in_ready", 64'(bus.in_ready), 64'(0));
    bus.out_ready = 1'b1;
    wait_drain("c_drain", DEPTH + 1);
    chk("c_tx_count", 64'(bus.tx_count), 64'(DEPTH + 1));

    // Reset with five transactions in flight.
    reset_dut();
    bus.out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      xv = {$urandom()};
      load(1'b0, xv);
      bus.in_valid = 1'b1;
      exp_q.push_back(expect_vec(1'b0, xv));
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("midrst_tx_count", 64'(bus.tx_count), 64'(0));
    chk("midrst_in_ready", 64'(bus.in_ready), 64'(1));
    exp_q.delete();
    n_out = 0;
    repeat (2) tick();
    rst = 1'b1;
    seen = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("midrst_stale", 64'(seen), 64'(0));
    s1 = 8'h12; s2 = 8'h34; s3 = 8'h35;
    xv = {LANES{s1 ^ s2 ^ s3}};
    load(1'b0, xv);
    bus.in_valid = 1'b1;
    exp_q.push_back(expect_vec(1'b0, xv));
    tick();
    bus.in_valid = 1'b0;
    repeat (CORE_LAT - 1) tick();
    chk("postrst_early", 64'(bus.out_valid), 64'(0));
    tick();
    chk("postrst_latency", 64'(bus.out_valid), 64'(1));
    wait_drain("postrst_drain", 1);
    chk("postrst_tx_count", 64'(bus.tx_count), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
